// File: rtl/ahb_ram_arbiter.sv
// Three-master AHB-lite front end for one single-port synchronous SRAM bank.
// SPI has fixed priority; imem and dmem alternate on conflict; losers see wait states.
module ahb_ram_arbiter #(
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              spi_hsel,
    input  logic              imem_hsel,
    input  logic              dmem_hsel,
    input  logic [31:0]       spi_haddr,
    input  logic [31:0]       imem_haddr,
    input  logic [31:0]       dmem_haddr,
    input  logic [1:0]        spi_htrans,
    input  logic [1:0]        imem_htrans,
    input  logic [1:0]        dmem_htrans,
    input  logic              spi_hwrite,
    input  logic              imem_hwrite,
    input  logic              dmem_hwrite,
    input  logic [2:0]        spi_hsize,
    input  logic [2:0]        imem_hsize,
    input  logic [2:0]        dmem_hsize,
    input  logic [31:0]       spi_hwdata,
    input  logic [31:0]       imem_hwdata,
    input  logic [31:0]       dmem_hwdata,
    output logic              spi_hready,
    output logic              imem_hready,
    output logic              dmem_hready,
    output logic              spi_hresp,
    output logic              imem_hresp,
    output logic              dmem_hresp,
    output logic [31:0]       spi_hrdata,
    output logic [31:0]       imem_hrdata,
    output logic [31:0]       dmem_hrdata,
    output logic              ram_en,
    output logic              ram_rwn,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [3:0]        ram_wben,
    output logic [31:0]       ram_wdata,
    input  logic [31:0]       ram_rdata,
    output logic              busy
);

    typedef enum logic [2:0] {
        S_IDLE, S_WR, S_RD_WAIT, S_RD_DONE, S_ERR1, S_ERR2
    } state_t;

    state_t            state, state_next;
    logic [2:0]        owner_oh;
    logic [ADDR_W-1:0] lat_waddr;
    logic [1:0]        lat_boff;
    logic [2:0]        lat_size;
    logic              rr_last;   // 0 = imem granted last, 1 = dmem

    logic [2:0]        req;
    logic [2:0]        gnt_oh;
    logic              can_accept;
    logic [31:0]       sel_addr;
    logic              sel_write;
    logic [2:0]        sel_size;
    logic [31:0]       owner_hwdata;
    logic [3:0]        lane_mask;
    logic [2:0]        hready;
    logic [2:0]        hresp;

    assign req = {dmem_hsel & dmem_htrans[1], imem_hsel & imem_htrans[1], spi_hsel & spi_htrans[1]};
    assign can_accept = !reset && (state == S_IDLE || state == S_WR || state == S_RD_DONE);

    always_comb begin
        gnt_oh = 3'b000;
        if (can_accept) begin
            if (req[0])
                gnt_oh = 3'b001;
            else if (req[1] && req[2])
                gnt_oh = rr_last ? 3'b010 : 3'b100;
            else if (req[1])
                gnt_oh = 3'b010;
            else if (req[2])
                gnt_oh = 3'b100;
        end
    end

    always_comb begin
        sel_addr  = spi_haddr;
        sel_write = spi_hwrite;
        sel_size  = spi_hsize;
        if (gnt_oh[1]) begin
            sel_addr  = imem_haddr;
            sel_write = imem_hwrite;
            sel_size  = imem_hsize;
        end else if (gnt_oh[2]) begin
            sel_addr  = dmem_haddr;
            sel_write = dmem_hwrite;
            sel_size  = dmem_hsize;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            owner_oh  <= 3'b000;
            lat_waddr <= '0;
            lat_boff  <= 2'b00;
            lat_size  <= 3'b000;
            rr_last   <= 1'b0;
        end else begin
            state <= state_next;
            if (gnt_oh != 3'b000) begin
                owner_oh  <= gnt_oh;
                lat_waddr <= sel_addr[ADDR_W+1:2];
                lat_boff  <= sel_addr[1:0];
                lat_size  <= sel_size;
                if (!gnt_oh[0])
                    rr_last <= gnt_oh[2];
            end
        end
    end

    always_comb begin
        state_next = S_IDLE;
        case (state)
            S_IDLE, S_WR, S_RD_DONE: begin
                if (gnt_oh != 3'b000) begin
                    if (sel_size > 3'b010)
                        state_next = S_ERR1;
                    else if (sel_write)
                        state_next = S_WR;
                    else
                        state_next = S_RD_WAIT;
                end
            end
            S_RD_WAIT: state_next = S_RD_DONE;
            S_ERR1:    state_next = S_ERR2;
            S_ERR2:    state_next = S_IDLE;
            default:   state_next = S_IDLE;
        endcase
    end

    always_comb begin
        owner_hwdata = spi_hwdata;
        if (owner_oh[1])
            owner_hwdata = imem_hwdata;
        else if (owner_oh[2])
            owner_hwdata = dmem_hwdata;
    end

    always_comb begin
        case (lat_size)
            3'b000:  lane_mask = 4'b0001 << lat_boff;
            3'b001:  lane_mask = lat_boff[1] ? 4'b1100 : 4'b0011;
            3'b010:  lane_mask = 4'b1111;
            default: lane_mask = 4'b0000;
        endcase
    end

    always_comb begin
        ram_en    = 1'b0;
        ram_rwn   = 1'b1;
        ram_addr  = '0;
        ram_wben  = 4'b0000;
        ram_wdata = 32'h0;
        if (!reset) begin
            if (state == S_WR) begin
                ram_en    = 1'b1;
                ram_rwn   = 1'b0;
                ram_addr  = lat_waddr;
                ram_wben  = lane_mask;
                ram_wdata = owner_hwdata;
            end else if (state == S_RD_WAIT) begin
                ram_en   = 1'b1;
                ram_addr = lat_waddr;
            end
        end
    end

    // Handshake: hready=0 holds a master either in its address phase (request
    // present but not granted) or in its data phase (owner in RD_WAIT/ERR1);
    // a request is taken exactly at the edge where it is seen with hready=1.
    always_comb begin
        hready = 3'b111;
        hresp  = 3'b000;
        if (!reset) begin
            hready = ~(req & ~gnt_oh);
            if (state == S_RD_WAIT || state == S_ERR1)
                hready = hready & ~owner_oh;
            if (state == S_ERR1 || state == S_ERR2)
                hresp = owner_oh;
        end
    end

    assign spi_hready  = hready[0];
    assign imem_hready = hready[1];
    assign dmem_hready = hready[2];
    assign spi_hresp   = hresp[0];
    assign imem_hresp  = hresp[1];
    assign dmem_hresp  = hresp[2];
    assign spi_hrdata  = ram_rdata;
    assign imem_hrdata = ram_rdata;
    assign dmem_hrdata = ram_rdata;
    assign busy        = !reset && (state != S_IDLE);

    logic unused_bits;
    assign unused_bits = ^{spi_haddr[31:ADDR_W+2], imem_haddr[31:ADDR_W+2], dmem_haddr[31:ADDR_W+2],
                           spi_htrans[0], imem_htrans[0], dmem_htrans[0]};

endmodule

// File: tb/tb_ahb_ram_arbiter.sv
// Randomized bench for ahb_ram_arbiter: transaction-level service-order model,
// reference memory and per-cycle hready/hresp/RAM-strobe expectations.
module tb_ahb_ram_arbiter;

    localparam int ADDR_W = 12;
    localparam int DEPTH  = 1 << ADDR_W;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [2:0]        hsel, hwrite;
    logic [1:0]        htrans[3];
    logic [31:0]       haddr[3];
    logic [2:0]        hsize[3];
    logic [31:0]       hwdata[3];
    logic [2:0]        hready, hresp;
    logic [31:0]       hrdata[3];
    logic              ram_en, ram_rwn, busy;
    logic [ADDR_W-1:0] ram_addr;
    logic [3:0]        ram_wben;
    logic [31:0]       ram_wdata;
    logic [31:0]       ram_rdata;

    int n_checks = 0;
    int n_pass   = 0;

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    ahb_ram_arbiter #(.ADDR_W(ADDR_W)) dut (
        .clk(clk), .reset(reset),
        .spi_hsel(hsel[0]), .imem_hsel(hsel[1]), .dmem_hsel(hsel[2]),
        .spi_haddr(haddr[0]), .imem_haddr(haddr[1]), .dmem_haddr(haddr[2]),
        .spi_htrans(htrans[0]), .imem_htrans(htrans[1]), .dmem_htrans(htrans[2]),
        .spi_hwrite(hwrite[0]), .imem_hwrite(hwrite[1]), .dmem_hwrite(hwrite[2]),
        .spi_hsize(hsize[0]), .imem_hsize(hsize[1]), .dmem_hsize(hsize[2]),
        .spi_hwdata(hwdata[0]), .imem_hwdata(hwdata[1]), .dmem_hwdata(hwdata[2]),
        .spi_hready(hready[0]), .imem_hready(hready[1]), .dmem_hready(hready[2]),
        .spi_hresp(hresp[0]), .imem_hresp(hresp[1]), .dmem_hresp(hresp[2]),
        .spi_hrdata(hrdata[0]), .imem_hrdata(hrdata[1]), .dmem_hrdata(hrdata[2]),
        .ram_en(ram_en), .ram_rwn(ram_rwn), .ram_addr(ram_addr),
        .ram_wben(ram_wben), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
        .busy(busy)
    );

    // RAM macro stand-in; preload port used only while the DUT is in reset
    logic [31:0]       mem[DEPTH];
    logic              pl_en = 1'b0;
    logic [ADDR_W-1:0] pl_addr = '0;
    logic [31:0]       pl_data = 32'h0;

    always @(posedge clk) begin
        if (pl_en)
            mem[pl_addr] <= pl_data;
        if (ram_en && ram_rwn)
            ram_rdata <= mem[ram_addr];
        if (ram_en && !ram_rwn)
            for (int b = 0; b < 4; b++)
                if (ram_wben[b])
                    mem[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
    end

    // ---------------- reference model state ----------------
    logic [31:0] ref_mem[16];
    logic        rr_last_m;            // 0: imem served last, 1: dmem
    logic [31:0] exp_q[$];             // read data in service order
    logic        op_v[3], op_w[3];
    logic [31:0] op_a[3], op_d[3];
    logic [2:0]  op_s[3];

    function automatic logic [3:0] lanes(input logic [2:0] s, input logic [31:0] a);
        case (s)
            3'd0:    return 4'(1 << (a % 4));
            3'd1:    return 4'(3 << (a & 2));
            default: return 4'hF;
        endcase
    endfunction

    function automatic logic [ADDR_W-1:0] word_of(input logic [31:0] a);
        return ADDR_W'((a >> 2) % DEPTH);
    endfunction

    // ---------------- scoreboard ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive_idle();
        for (int m = 0; m < 3; m++) begin
            hsel[m] = 1'b0; htrans[m] = 2'b00; haddr[m] = 32'h0;
            hwrite[m] = 1'b0; hsize[m] = 3'b000; hwdata[m] = 32'h0;
        end
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_hready"}, 32'(hready), 32'h7);
        check({tag, "_hresp"}, 32'(hresp), 32'h0);
        check({tag, "_ram_en"}, 32'(ram_en), 32'h0);
        check({tag, "_busy"}, 32'(busy), 32'h0);
    endtask

    task automatic reset_dut();
        reset = 1'b1;
        drive_idle();
        @(posedge clk);
        @(posedge clk);
        #1 reset = 1'b0;
        rr_last_m = 1'b0;
        @(negedge clk);
        check_quiet("rst");
        check("rst_ram_rwn", 32'(ram_rwn), 32'h1);
        check("rst_ram_addr", 32'(ram_addr), 32'h0);
        check("rst_ram_wben", 32'(ram_wben), 32'h0);
        check("rst_ram_wdata", ram_wdata, 32'h0);
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input int m, input logic w, input logic [2:0] s,
                          input logic [31:0] a, input logic [31:0] d);
        op_v[m] = 1'b1; op_w[m] = w; op_s[m] = s; op_a[m] = a; op_d[m] = d;
    endtask

    task automatic clear_ops();
        for (int m = 0; m < 3; m++) begin
            op_v[m] = 1'b0; op_w[m] = 1'b0; op_s[m] = 3'd0; op_a[m] = 32'h0; op_d[m] = 32'h0;
        end
    endtask

    // All valid ops are presented together in cycle 0 and held until accepted.
    // The model serialises them (SPI, then round-robin) and assigns each an
    // accept cycle: a write frees the arbiter 1 cycle later, a read 2, an error 3.
    task automatic run_round();
        int ord[$];
        int acc[3], done_c[3], seen[3];
        bit pending[3];
        int t, n_cyc, en_m;
        bit exp_en, exp_busy, err;
        logic exp_rdy, exp_rsp;
        logic [3:0] be;
        logic [31:0] v;
        if (op_v[0]) ord.push_back(0);
        if (op_v[1] && op_v[2]) begin
            if (rr_last_m == 1'b0) begin ord.push_back(2); ord.push_back(1); end
            else begin ord.push_back(1); ord.push_back(2); end
            rr_last_m = (ord[ord.size()-1] == 2);
        end else if (op_v[1]) begin
            ord.push_back(1); rr_last_m = 1'b0;
        end else if (op_v[2]) begin
            ord.push_back(2); rr_last_m = 1'b1;
        end
        for (int m = 0; m < 3; m++) begin acc[m] = -10; done_c[m] = -10; seen[m] = -10; end
        t = 0;
        foreach (ord[k]) begin
            int m;
            m = ord[k];
            acc[m] = t;
            if (op_s[m] > 3'd2) begin
                done_c[m] = t + 2; t += 3;
            end else if (op_w[m]) begin
                be = lanes(op_s[m], op_a[m]);
                v = ref_mem[(op_a[m] >> 2) % 16];
                for (int b = 0; b < 4; b++)
                    if (be[b]) v[8*b +: 8] = op_d[m][8*b +: 8];
                ref_mem[(op_a[m] >> 2) % 16] = v;
                done_c[m] = t + 1; t += 1;
            end else begin
                exp_q.push_back(ref_mem[(op_a[m] >> 2) % 16]);
                done_c[m] = t + 2; t += 2;
            end
        end
        n_cyc = t + 2;
        for (int m = 0; m < 3; m++) pending[m] = op_v[m];
        for (int c = 0; c < n_cyc; c++) begin
            for (int m = 0; m < 3; m++) begin
                if (pending[m]) begin
                    hsel[m] = 1'b1; htrans[m] = {1'b1, 1'($urandom)}; haddr[m] = op_a[m];
                    hwrite[m] = op_w[m]; hsize[m] = op_s[m];
                end else begin
                    hsel[m] = 1'($urandom); htrans[m] = {1'b0, 1'($urandom)}; haddr[m] = $urandom;
                    hwrite[m] = 1'($urandom); hsize[m] = 3'($urandom);
                end
                hwdata[m] = (c == seen[m] + 1) ? op_d[m] : $urandom;
            end
            @(negedge clk);
            exp_en = 1'b0; exp_busy = 1'b0; en_m = 0;
            for (int m = 0; m < 3; m++) begin
                err = op_s[m] > 3'd2;
                exp_rdy = 1'b1; exp_rsp = 1'b0;
                if (op_v[m]) begin
                    if (c < acc[m]) exp_rdy = 1'b0;
                    if (c == acc[m] + 1 && (err || !op_w[m])) exp_rdy = 1'b0;
                    if (err && (c == acc[m] + 1 || c == acc[m] + 2)) exp_rsp = 1'b1;
                    if (!err && c == acc[m] + 1) begin exp_en = 1'b1; en_m = m; end
                    if (c > acc[m] && c <= done_c[m]) exp_busy = 1'b1;
                    if (!err && !op_w[m] && c == acc[m] + 2)
                        check($sformatf("hrdata%0d_c%0d", m, c), hrdata[m], exp_q.pop_front());
                end
                check($sformatf("hready%0d_c%0d", m, c), 32'(hready[m]), 32'(exp_rdy));
                check($sformatf("hresp%0d_c%0d", m, c), 32'(hresp[m]), 32'(exp_rsp));
            end
            check($sformatf("ram_en_c%0d", c), 32'(ram_en), 32'(exp_en));
            check($sformatf("busy_c%0d", c), 32'(busy), 32'(exp_busy));
            if (exp_en) begin
                check($sformatf("ram_rwn_c%0d", c), 32'(ram_rwn), 32'(!op_w[en_m]));
                check($sformatf("ram_addr_c%0d", c), 32'(ram_addr), 32'(word_of(op_a[en_m])));
                if (op_w[en_m]) begin
                    check($sformatf("ram_wben_c%0d", c), 32'(ram_wben), 32'(lanes(op_s[en_m], op_a[en_m])));
                    check($sformatf("ram_wdata_c%0d", c), ram_wdata, op_d[en_m]);
                end
            end
            for (int m = 0; m < 3; m++)
                if (pending[m] && hready[m]) begin pending[m] = 1'b0; seen[m] = c; end
            @(posedge clk);
            #1;
        end
        for (int m = 0; m < 3; m++)
            if (pending[m]) check($sformatf("never_accepted%0d", m), 32'h1, 32'h0);
        drive_idle();
    endtask

    function automatic logic [31:0] rand_addr();
        return ($urandom & 32'hFFFF_C000) | (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3));
    endfunction

    // ---------------- stimulus ----------------
    initial begin
        drive_idle();
        clear_ops();
        reset = 1'b1;
        for (int i = 0; i < 16; i++) begin
            pl_en = 1'b1;
            pl_addr = ADDR_W'(i);
            pl_data = (i == 4) ? 32'hDEADBEEF : $urandom;
            ref_mem[i] = pl_data;
            @(posedge clk);
            #1;
        end
        pl_en = 1'b0;
        reset_dut();

        // read latency: imem word 4
        clear_ops(); set_op(1, 1'b0, 3'd2, 32'h0000_0010, 32'h0); run_round();
        // byte write to lane 3, then word read back
        clear_ops(); set_op(2, 1'b1, 3'd0, 32'h0000_0007, {4{8'hAB}}); run_round();
        clear_ops(); set_op(2, 1'b0, 3'd2, 32'h0000_0004, 32'h0); run_round();
        // round-robin conflicts from reset
        reset_dut();
        for (int k = 0; k < 3; k++) begin
            clear_ops();
            set_op(1, 1'b0, 3'd2, rand_addr(), 32'h0);
            set_op(2, 1'b0, 3'd2, rand_addr(), 32'h0);
            run_round();
        end
        // SPI priority with three simultaneous writes
        reset_dut();
        clear_ops();
        set_op(0, 1'b1, 3'd2, 32'h0000_0020, $urandom);
        set_op(1, 1'b1, 3'd2, 32'h0000_0024, $urandom);
        set_op(2, 1'b1, 3'd2, 32'h0000_0028, $urandom);
        run_round();
        // error response
        clear_ops(); set_op(1, 1'b0, 3'd3, 32'h0000_0010, 32'h0); run_round();

        // reset during RD_WAIT
        hsel[1] = 1'b1; htrans[1] = 2'b10; haddr[1] = 32'h10; hwrite[1] = 1'b0; hsize[1] = 3'd2;
        @(negedge clk);
        check("t6_rd_accept", 32'(hready[1]), 32'h1);
        @(posedge clk);
        #1 drive_idle(); reset = 1'b1;
        @(negedge clk);
        check("t6_rd_rst_en", 32'(ram_en), 32'h0);
        @(posedge clk);
        #1 reset = 1'b0; rr_last_m = 1'b0;
        @(negedge clk);
        check_quiet("t6_rd_after");
        @(posedge clk);
        #1;
        // reset during WR: the write must not reach the RAM
        hsel[2] = 1'b1; htrans[2] = 2'b10; haddr[2] = 32'h10; hwrite[2] = 1'b1; hsize[2] = 3'd2;
        @(negedge clk);
        check("t6_wr_accept", 32'(hready[2]), 32'h1);
        @(posedge clk);
        #1 drive_idle(); hwdata[2] = 32'h1234_5678; reset = 1'b1;
        @(negedge clk);
        check("t6_wr_rst_en", 32'(ram_en), 32'h0);
        check("t6_wr_rst_wben", 32'(ram_wben), 32'h0);
        @(posedge clk);
        #1 reset = 1'b0; rr_last_m = 1'b0; drive_idle();
        @(negedge clk);
        check_quiet("t6_wr_after");
        @(posedge clk);
        #1;
        clear_ops(); set_op(1, 1'b0, 3'd2, 32'h0000_0010, 32'h0); run_round();

        // randomized rounds
        for (int r = 0; r < 250; r++) begin
            for (int m = 0; m < 3; m++) begin
                op_v[m] = ($urandom_range(0, 3) != 0);
                op_w[m] = 1'($urandom);
                op_s[m] = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
                op_a[m] = rand_addr();
                op_d[m] = $urandom;
            end
            run_round();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
